// File: rtl/layer_bridge_pkg.sv
// Shared definitions for the inter-layer bridge: serializer states and
// sizing helpers used by the bridge and its vector buffer.
package layer_bridge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Ceiling log2, usable in constant (parameter) context.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Width of an occupancy count able to hold 0..depth inclusive.
  function automatic int level_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/layer_bridge_vec_fifo.sv
// Register-based FIFO of whole vectors. A push into a full buffer is
// accepted when a pop happens at the same edge; the head entry is
// readable combinationally.
module vec_fifo
  import layer_bridge_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 48
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              din,
  output logic [W-1:0]              head,
  output logic                      full,
  output logic                      empty,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          do_push;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign head    = mem[rd_ptr];
  assign do_push = push && (!full || pop);

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
  // pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Vector storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/layer_bridge.sv
// Link between a producing layer and the next layer's serial input:
// per-neuron alignment barrier with optional partial-vector timeout,
// a vector buffer, and a TRIGGER-paced element serializer.
module layer_bridge
  import layer_bridge_pkg::*;
#(
  parameter int NUM_NEURONS = 6,
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 2,
  parameter int TIMEOUT     = 0
) (
  input  logic                         CLK,
  input  logic                         RSTN,
  input  logic [NUM_NEURONS*WIDTH-1:0] VALUES_IN,
  input  logic [NUM_NEURONS-1:0]       VALIDS_IN,
  input  logic                         TRIGGER,
  input  logic                         CLEAR,
  output logic [WIDTH-1:0]             VALUE_OUT,
  output logic                         VALID_OUT,
  output logic                         LAST_OUT,
  output logic [level_w(DEPTH)-1:0]    LEVEL,
  output logic                         BUSY,
  output logic                         DROP,
  output logic                         TIMEOUT_ERR
);

  localparam int VW = NUM_NEURONS * WIDTH;
  localparam int LW = level_w(DEPTH);
  localparam int KW = (clog2(NUM_NEURONS) > 0) ? clog2(NUM_NEURONS) : 1;
  localparam int TW = clog2(TIMEOUT + 2);
  localparam logic [KW-1:0] K_LAST = KW'(NUM_NEURONS - 1);
  localparam logic [TW-1:0] T_LIM  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [NUM_NEURONS-1:0] mask_p0;
  logic [VW-1:0]          cap_p0;
  logic [TW-1:0]          tcnt_p0;
  state_t                 state_p1;
  logic [KW-1:0]          k_p1;

  logic [VW-1:0]          merged;
  logic                   complete;
  logic                   tmo_hit;
  logic                   pop;
  logic                   push_ok;
  logic                   drop_set;
  logic [VW-1:0]          head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [LW-1:0]          fifo_level;

  // ---- barrier stage: merge captured elements with same-cycle arrivals ----
  assign complete = &(mask_p0 | VALIDS_IN);
  assign tmo_hit  = (TIMEOUT > 0) && (mask_p0 != '0) && !complete && (tcnt_p0 == T_LIM);
  assign pop      = (state_p1 == SEND) && TRIGGER && (k_p1 == K_LAST);
  assign push_ok  = complete && (!fifo_full || pop);
  assign drop_set = complete && fifo_full && !pop;

  // Overlay incoming valid elements on the captured vector (last write wins).
  always_comb begin
    merged = cap_p0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (VALIDS_IN[i]) merged[i*WIDTH +: WIDTH] = VALUES_IN[i*WIDTH +: WIDTH];
    end
  end

  // Barrier mask, element capture and partial-vector age counter.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mask_p0 <= '0;
      cap_p0  <= '0;
      tcnt_p0 <= '0;
    end else begin
      cap_p0 <= merged;
      if (complete || tmo_hit) mask_p0 <= '0;
      else                     mask_p0 <= mask_p0 | VALIDS_IN;
      if ((mask_p0 == '0) || complete || tmo_hit) tcnt_p0 <= '0;
      else                                        tcnt_p0 <= tcnt_p0 + TW'(1);
    end
  end

  // Sticky error flags; a new set event takes priority over CLEAR.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      DROP        <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      DROP        <= drop_set | (DROP & ~CLEAR);
      TIMEOUT_ERR <= tmo_hit  | (TIMEOUT_ERR & ~CLEAR);
    end
  end

  // ---- buffer stage: completed vectors wait here for the serializer ----
  vec_fifo #(
    .DEPTH (DEPTH),
    .W     (VW)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RSTN),
    .push  (complete),
    .pop   (pop),
    .din   (merged),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // ---- serializer stage: one element of the head vector per TRIGGER edge ----
  // After the last element the FSM stays in SEND if another vector remains,
  // so consecutive vectors stream without a gap.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_p1  <= IDLE;
      k_p1      <= '0;
      VALUE_OUT <= '0;
      VALID_OUT <= 1'b0;
      LAST_OUT  <= 1'b0;
    end else begin
      VALID_OUT <= 1'b0;
      LAST_OUT  <= 1'b0;
      case (state_p1)
        IDLE: if (!fifo_empty) state_p1 <= SEND;
        SEND: begin
          if (TRIGGER) begin
            VALUE_OUT <= head[k_p1*WIDTH +: WIDTH];
            VALID_OUT <= 1'b1;
            LAST_OUT  <= (k_p1 == K_LAST);
            if (k_p1 == K_LAST) begin
              k_p1 <= '0;
              if (!((fifo_level > LW'(1)) || push_ok)) state_p1 <= IDLE;
            end else begin
              k_p1 <= k_p1 + KW'(1);
            end
          end
        end
        default: state_p1 <= IDLE;
      endcase
    end
  end

  assign LEVEL = fifo_level;
  assign BUSY  = (mask_p0 != '0) || !fifo_empty || (state_p1 == SEND);

endmodule

// File: tb/tb_layer_bridge.sv
// Bench for layer_bridge (3 neurons x 8 bits, 2-deep buffer, timeout 8):
// directed scenarios plus random traffic against a queue-based reference.
module tb_layer_bridge;

  localparam int N = 3;
  localparam int W = 8;
  localparam int D = 2;
  localparam int T = 8;

  logic           CLK = 1'b0;
  logic           RSTN = 1'b0;
  logic [N*W-1:0] VALUES_IN;
  logic [N-1:0]   VALIDS_IN;
  logic           TRIGGER;
  logic           CLEAR;
  logic [W-1:0]   VALUE_OUT;
  logic           VALID_OUT;
  logic           LAST_OUT;
  logic [1:0]     LEVEL;
  logic           BUSY;
  logic           DROP;
  logic           TIMEOUT_ERR;

  int total = 0;
  int bad   = 0;
  string phase = "init";

  layer_bridge #(
    .NUM_NEURONS (N),
    .WIDTH       (W),
    .DEPTH       (D),
    .TIMEOUT     (T)
  ) dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .VALUES_IN   (VALUES_IN),
    .VALIDS_IN   (VALIDS_IN),
    .TRIGGER     (TRIGGER),
    .CLEAR       (CLEAR),
    .VALUE_OUT   (VALUE_OUT),
    .VALID_OUT   (VALID_OUT),
    .LAST_OUT    (LAST_OUT),
    .LEVEL       (LEVEL),
    .BUSY        (BUSY),
    .DROP        (DROP),
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  // Reference state: partial vector being gathered, buffered vectors,
  // position in the vector being sent, and the flag/output values.
  logic [W-1:0]   m_cap [N];
  bit             m_have [N];
  int             m_age;
  logic [N*W-1:0] m_q [$];
  bit             m_send;
  int             m_k;
  logic [W-1:0]   m_val;
  bit             m_vld, m_last, m_drop, m_terr;

  function automatic logic [N*W-1:0] vec(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c);
    return {c, b, a};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cap[i]  = '0;
      m_have[i] = 1'b0;
    end
    m_age = 0;
    m_q.delete();
    m_send = 1'b0;
    m_k = 0;
    m_val = '0;
    m_vld = 1'b0;
    m_last = 1'b0;
    m_drop = 1'b0;
    m_terr = 1'b0;
  endtask

  // One clock edge of the reference, from the inputs present at that edge.
  task automatic model_edge(input logic [N*W-1:0] vin, input logic [N-1:0] vv,
                            input bit trig, input bit clr);
    bit all, any, tmo, popd, acc;
    int sz;
    logic [W-1:0]   el [N];
    logic [N*W-1:0] merged;
    logic [N*W-1:0] hv;
    all = 1'b1;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!(m_have[i] || vv[i])) all = 1'b0;
      if (m_have[i]) any = 1'b1;
      el[i] = vv[i] ? vin[i*W +: W] : m_cap[i];
    end
    merged = {el[2], el[1], el[0]};
    tmo = any && !all && (m_age + 1 == T);
    sz = m_q.size();
    popd = 1'b0;
    m_vld = 1'b0;
    m_last = 1'b0;
    if (m_send && trig) begin
      hv = m_q[0];
      m_val = hv[m_k*W +: W];
      m_vld = 1'b1;
      m_last = (m_k == N - 1);
      if (m_k == N - 1) begin
        popd = 1'b1;
        m_k = 0;
      end else begin
        m_k = m_k + 1;
      end
    end
    acc = all && (sz < D || popd);
    m_drop = (all && !acc) ? 1'b1 : (clr ? 1'b0 : m_drop);
    m_terr = tmo ? 1'b1 : (clr ? 1'b0 : m_terr);
    if (popd) void'(m_q.pop_front());
    if (acc) m_q.push_back(merged);
    if (!m_send) m_send = (sz > 0);
    else if (popd) m_send = (m_q.size() > 0);
    if (all || tmo) begin
      for (int i = 0; i < N; i++) m_have[i] = 1'b0;
      m_age = 0;
    end else begin
      if (any) m_age = m_age + 1;
      else     m_age = 0;
      for (int i = 0; i < N; i++) if (vv[i]) m_have[i] = 1'b1;
    end
    for (int i = 0; i < N; i++) m_cap[i] = el[i];
  endtask

  function automatic bit model_busy();
    bit b;
    b = m_send || (m_q.size() > 0);
    for (int i = 0; i < N; i++) if (m_have[i]) b = 1'b1;
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("value_out", 32'(VALUE_OUT), 32'(m_val));
    check("valid_out", 32'(VALID_OUT), 32'(m_vld));
    check("last_out", 32'(LAST_OUT), 32'(m_last));
    check("level", 32'(LEVEL), 32'(m_q.size()));
    check("busy", 32'(BUSY), 32'(model_busy()));
    check("drop", 32'(DROP), 32'(m_drop));
    check("timeout_err", 32'(TIMEOUT_ERR), 32'(m_terr));
  endtask

  task automatic step(input logic [N*W-1:0] vin, input logic [N-1:0] vv,
                      input bit trig, input bit clr);
    VALUES_IN = vin;
    VALIDS_IN = vv;
    TRIGGER = trig;
    CLEAR = clr;
    @(posedge CLK);
    model_edge(vin, vv, trig, clr);
    #1;
    compare_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [W-1:0] got [6];
    logic [N*W-1:0] va, vb, vc;

    VALUES_IN = '0;
    VALIDS_IN = '0;
    TRIGGER = 1'b0;
    CLEAR = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    phase = "reset";
    compare_all();
    RSTN = 1'b1;

    // Skewed valids: elements arrive at edges 0, 2, 4.
    phase = "skew";
    step(vec(8'h11, 8'h00, 8'h00), 3'b001, 1'b1, 1'b0);
    step('0, 3'b000, 1'b1, 1'b0);
    step(vec(8'h00, 8'h00, 8'h33), 3'b100, 1'b1, 1'b0);
    step('0, 3'b000, 1'b1, 1'b0);
    step(vec(8'h00, 8'h22, 8'h00), 3'b010, 1'b1, 1'b0);
    step('0, 3'b000, 1'b1, 1'b0);
    for (int e = 0; e < 3; e++) begin
      step('0, 3'b000, 1'b1, 1'b0);
      check("skew_valid", 32'(VALID_OUT), 32'd1);
      check("skew_value", 32'(VALUE_OUT), (e == 0) ? 32'h11 : (e == 1) ? 32'h22 : 32'h33);
      check("skew_last", 32'(LAST_OUT), (e == 2) ? 32'd1 : 32'd0);
    end
    step('0, 3'b000, 1'b1, 1'b0);
    check("skew_busy_end", 32'(BUSY), 32'd0);

    // TRIGGER stalls: pulses only after TRIGGER=1 edges.
    phase = "stall";
    step(vec(8'h01, 8'h02, 8'h03), 3'b111, 1'b0, 1'b0);
    step('0, 3'b000, 1'b0, 1'b0);
    n = 0;
    for (int e = 0; e < 5; e++) begin
      step('0, 3'b000, (e % 2 == 0), 1'b0);
      if (VALID_OUT && n < 6) begin
        got[n] = VALUE_OUT;
        n++;
      end
    end
    check("stall_pulses", 32'(n), 32'd3);
    check("stall_v0", 32'(got[0]), 32'h01);
    check("stall_v2", 32'(got[2]), 32'h03);
    step('0, 3'b000, 1'b0, 1'b0);

    // Overflow: third vector is dropped, first two stream back-to-back.
    phase = "overflow";
    va = vec(8'hA0, 8'hA1, 8'hA2);
    vb = vec(8'hB0, 8'hB1, 8'hB2);
    vc = vec(8'hC0, 8'hC1, 8'hC2);
    step(va, 3'b111, 1'b0, 1'b0);
    step(vb, 3'b111, 1'b0, 1'b0);
    step(vc, 3'b111, 1'b0, 1'b0);
    check("ovf_level", 32'(LEVEL), 32'd2);
    check("ovf_drop", 32'(DROP), 32'd1);
    n = 0;
    for (int e = 0; e < 6; e++) begin
      step('0, 3'b000, 1'b1, 1'b0);
      if (VALID_OUT) begin
        got[n] = VALUE_OUT;
        n++;
      end
    end
    check("ovf_contig", 32'(n), 32'd6);
    check("ovf_a0", 32'(got[0]), 32'hA0);
    check("ovf_b0", 32'(got[3]), 32'hB0);
    check("ovf_b2", 32'(got[5]), 32'hB2);
    for (int e = 0; e < 3; e++) begin
      step('0, 3'b000, 1'b1, 1'b0);
      check("ovf_no_c", 32'(VALID_OUT), 32'd0);
    end
    step('0, 3'b000, 1'b1, 1'b1);
    check("ovf_clear", 32'(DROP), 32'd0);

    // Timeout: a lone element is discarded after 8 edges.
    phase = "timeout";
    step(vec(8'h55, 8'h00, 8'h00), 3'b001, 1'b1, 1'b0);
    repeat (7) step('0, 3'b000, 1'b1, 1'b0);
    check("tmo_not_yet", 32'(TIMEOUT_ERR), 32'd0);
    step('0, 3'b000, 1'b1, 1'b0);
    check("tmo_err", 32'(TIMEOUT_ERR), 32'd1);
    check("tmo_busy", 32'(BUSY), 32'd0);
    check("tmo_level", 32'(LEVEL), 32'd0);
    step('0, 3'b000, 1'b1, 1'b1);
    step(vec(8'h21, 8'h22, 8'h23), 3'b111, 1'b1, 1'b0);
    repeat (5) step('0, 3'b000, 1'b1, 1'b0);

    // Completion on the timeout edge wins.
    phase = "tmo_edge";
    step(vec(8'h41, 8'h00, 8'h00), 3'b001, 1'b0, 1'b0);
    repeat (7) step('0, 3'b000, 1'b0, 1'b0);
    step(vec(8'h00, 8'h42, 8'h43), 3'b110, 1'b0, 1'b0);
    check("tmo_edge_err", 32'(TIMEOUT_ERR), 32'd0);
    check("tmo_edge_level", 32'(LEVEL), 32'd1);
    repeat (5) step('0, 3'b000, 1'b1, 1'b0);

    // Push into a full buffer on the edge the head pops.
    phase = "full_pop";
    step(va, 3'b111, 1'b0, 1'b0);
    step(vb, 3'b111, 1'b0, 1'b0);
    step('0, 3'b000, 1'b0, 1'b0);
    step('0, 3'b000, 1'b1, 1'b0);
    step('0, 3'b000, 1'b1, 1'b0);
    step(vc, 3'b111, 1'b1, 1'b0);
    check("fp_last", 32'(LAST_OUT), 32'd1);
    check("fp_drop", 32'(DROP), 32'd0);
    check("fp_level", 32'(LEVEL), 32'd2);
    n = 0;
    for (int e = 0; e < 6; e++) begin
      step('0, 3'b000, 1'b1, 1'b0);
      if (VALID_OUT) begin
        got[n] = VALUE_OUT;
        n++;
      end
    end
    check("fp_count", 32'(n), 32'd6);
    check("fp_c0", 32'(got[3]), 32'hC0);
    step('0, 3'b000, 1'b1, 1'b0);

    // Reset in the middle of serialization.
    phase = "reset_mid";
    step(vec(8'h61, 8'h62, 8'h63), 3'b111, 1'b1, 1'b0);
    step('0, 3'b000, 1'b1, 1'b0);
    step('0, 3'b000, 1'b1, 1'b0);
    step('0, 3'b000, 1'b1, 1'b0);
    RSTN = 1'b0;
    model_reset();
    #2;
    compare_all();
    check("rst_valid", 32'(VALID_OUT), 32'd0);
    check("rst_level", 32'(LEVEL), 32'd0);
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    repeat (4) step('0, 3'b000, 1'b1, 1'b0);
    step(vec(8'h7F, 8'h80, 8'h00), 3'b111, 1'b1, 1'b0);
    step('0, 3'b000, 1'b1, 1'b0);
    n = 0;
    for (int e = 0; e < 3; e++) begin
      step('0, 3'b000, 1'b1, 1'b0);
      if (VALID_OUT) begin
        got[n] = VALUE_OUT;
        n++;
      end
    end
    check("post_rst_count", 32'(n), 32'd3);
    check("post_rst_e0", 32'(got[0]), 32'h7F);
    check("post_rst_e1", 32'(got[1]), 32'h80);
    check("post_rst_e2", 32'(got[2]), 32'h00);

    // Random traffic against the reference.
    phase = "random";
    for (int s = 0; s < 600; s++) begin
      logic [N-1:0] vv;
      vv = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 7)) : '0;
      step(N*W'($urandom), vv, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
